// File: rtl/draw_sequencer_if.sv
// Bundle between the frame sequencer and its environment (frame timer, object
// mask sources, screen-clear engine, rectangle drawer, display mux).
// The sequencer is the master: it issues clear/draw requests and the mux select.
interface draw_sequencer_if;
    logic       frame_tick;
    logic       enable;
    logic [3:0] enemy_alive;
    logic       bullet_active;
    logic       show_health;
    logic       clear_done;
    logic       draw_done;
    logic [3:0] control_signal;
    logic       clear_start;
    logic       draw_start;
    logic       frame_busy;
    logic       frame_done;
    logic       frame_overrun;
    logic       timeout_err;

    modport master (
        input  frame_tick, enable, enemy_alive, bullet_active, show_health,
               clear_done, draw_done,
        output control_signal, clear_start, draw_start, frame_busy,
               frame_done, frame_overrun, timeout_err
    );

    modport slave (
        output frame_tick, enable, enemy_alive, bullet_active, show_health,
               clear_done, draw_done,
        input  control_signal, clear_start, draw_start, frame_busy,
               frame_done, frame_overrun, timeout_err
    );
endinterface

// File: rtl/draw_sequencer.sv
// Per-frame draw scheduler: on a frame tick it requests a screen clear, then
// walks mux slots 1..NUM_SLOTS (player, enemies, bullet, health bars), skipping
// inactive objects and handshaking each rectangle with the drawer.
// Optional build macro: DRAW_TIMEOUT_EN adds a watchdog on the clear/draw waits
// that abandons a stuck item and raises a sticky timeout_err.
module draw_sequencer #(
    parameter int NUM_SLOTS      = 14,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic              clk,
    input  logic              reset,
    draw_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, CLEAR_REQ, CLEAR_WAIT, SELECT, SETTLE, DRAW_REQ, DRAW_WAIT, FINISH
    } state_t;

    localparam int              SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [4:0]      LAST_SLOT   = 5'(NUM_SLOTS);

    state_t        state_q;
    logic [4:0]    slot_q;      // 5 bits so NUM_SLOTS+1 is representable without wrap
    logic [SW-1:0] settle_q;
    logic [3:0]    ctrl_q;
    logic          clear_start_q, draw_start_q, busy_q, done_q, overrun_q;
    logic          slot_en;
    logic          wdog_hit;
    logic [4:0]    off_enemy, off_bar;

    assign off_enemy = slot_q - 5'd2;
    assign off_bar   = slot_q - 5'd7;

    // Slot enable from the live object masks: bars come in pairs per enemy
    always_comb begin
        slot_en = 1'b0;
        if (slot_q == 5'd1)
            slot_en = 1'b1;
        else if (slot_q >= 5'd2 && slot_q <= 5'd5)
            slot_en = bus.enemy_alive[off_enemy[1:0]];
        else if (slot_q == 5'd6)
            slot_en = bus.bullet_active;
        else if (slot_q >= 5'd7 && slot_q <= 5'd14)
            slot_en = bus.show_health & bus.enemy_alive[off_bar[2:1]];
    end

`ifdef DRAW_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wdog_q;
    logic          timeout_q;

    assign wdog_hit        = (wdog_q == TO_LAST);
    assign bus.timeout_err = timeout_q;

    // Watchdog: restarts in the request cycle, counts each waiting cycle without a done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == CLEAR_REQ || state_q == DRAW_REQ) begin
            wdog_q <= '0;
        end else if ((state_q == CLEAR_WAIT && !bus.clear_done) ||
                     (state_q == DRAW_WAIT  && !bus.draw_done)) begin
            if (wdog_hit) timeout_q <= 1'b1;
            else          wdog_q    <= wdog_q + 1'b1;
        end
    end
`else
    // Watchdog compiled out: waits are unbounded and the flag can never rise
    assign wdog_hit        = 1'b0;
    assign bus.timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    // Main sequencer FSM with registered outputs; pulses default low each cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            slot_q        <= 5'd1;
            settle_q      <= '0;
            ctrl_q        <= '0;
            clear_start_q <= 1'b0;
            draw_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            clear_start_q <= 1'b0;
            draw_start_q  <= 1'b0;
            done_q        <= 1'b0;
            if (bus.frame_tick && busy_q) overrun_q <= 1'b1;
            case (state_q)
                IDLE: if (bus.frame_tick && bus.enable) begin
                    state_q       <= CLEAR_REQ;
                    slot_q        <= 5'd1;
                    busy_q        <= 1'b1;
                    clear_start_q <= 1'b1;
                end
                CLEAR_REQ:  state_q <= CLEAR_WAIT;
                CLEAR_WAIT: if (bus.clear_done || wdog_hit) state_q <= SELECT;
                SELECT: begin
                    if (slot_q > LAST_SLOT) begin
                        state_q <= FINISH;
                        ctrl_q  <= '0;
                        done_q  <= 1'b1;
                    end else if (slot_en) begin
                        ctrl_q   <= slot_q[3:0];
                        settle_q <= '0;
                        state_q  <= SETTLE;
                    end else begin
                        slot_q <= slot_q + 5'd1;
                    end
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q      <= DRAW_REQ;
                        draw_start_q <= 1'b1;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                DRAW_REQ:  state_q <= DRAW_WAIT;
                DRAW_WAIT: if (bus.draw_done || wdog_hit) begin
                    slot_q  <= slot_q + 5'd1;
                    state_q <= SELECT;
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.control_signal = ctrl_q;
    assign bus.clear_start    = clear_start_q;
    assign bus.draw_start     = draw_start_q;
    assign bus.frame_busy     = busy_q;
    assign bus.frame_done     = done_q;
    assign bus.frame_overrun  = overrun_q;
endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: directed steps plus randomized
// object masks and drawer latencies, checked against a slot-list model.
module tb_draw_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    draw_sequencer_if bus ();
    draw_sequencer #(.NUM_SLOTS(14), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int got_q[$];
    int n_done, n_clear;
    bit finished;
    logic busy_at_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: player, each live enemy, bullet, then both bars of each live enemy
    task automatic set_masks(input logic [3:0] alive, input logic bullet, input logic health);
        bus.enemy_alive   = alive;
        bus.bullet_active = bullet;
        bus.show_health   = health;
        exp_q.delete();
        exp_q.push_back(1);
        for (int e = 0; e < 4; e++) if (alive[e]) exp_q.push_back(2 + e);
        if (bullet) exp_q.push_back(6);
        if (health)
            for (int e = 0; e < 4; e++)
                if (alive[e]) begin
                    exp_q.push_back(7 + 2 * e);
                    exp_q.push_back(8 + 2 * e);
                end
    endtask

    // Tick, answer clear/draw requests, log draw selects; stop_slot leaves that draw unanswered
    task automatic run_frame(input int dly, input int inject_slot, input int stop_slot);
        int cd_clear;
        int cd_draw;
        int tail;
        cd_clear = -1; cd_draw = -1; tail = 5;
        got_q.delete(); n_done = 0; n_clear = 0; finished = 0; busy_at_done = 1'b0;
        @(negedge clk);
        bus.frame_tick = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            bus.frame_tick = 1'b0;
            bus.clear_done = 1'b0;
            bus.draw_done  = 1'b0;
            if (bus.clear_start) begin n_clear++; cd_clear = 2; end
            if (bus.draw_start) begin
                got_q.push_back(int'(bus.control_signal));
                if (int'(bus.control_signal) == stop_slot) return;
                if (int'(bus.control_signal) == inject_slot) bus.frame_tick = 1'b1;
                cd_draw = dly;
            end
            if (bus.frame_done) begin
                n_done++;
                if (!finished) busy_at_done = bus.frame_busy;
                finished = 1;
            end
            if (finished) begin
                if (tail == 0) return;
                tail--;
            end
            if (cd_clear == 0) begin bus.clear_done = 1'b1; cd_clear = -1; end
            else if (cd_clear > 0) cd_clear--;
            if (cd_draw == 0) begin bus.draw_done = 1'b1; cd_draw = -1; end
            else if (cd_draw > 0) cd_draw--;
        end
        chk("frame_budget", 32'(finished), 1);
    endtask

    task automatic compare_frame(input string tag);
        chk({tag, ".len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s.slot%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, ".frame_done"}, n_done, 1);
        chk({tag, ".clear_start"}, n_clear, 1);
        chk({tag, ".busy_at_done"}, 32'(busy_at_done), 1);
    endtask

    initial begin
        bit seen;
        int cnt;
        reset = 1'b1;
        bus.frame_tick = 1'b0; bus.enable = 1'b1; bus.enemy_alive = '0;
        bus.bullet_active = 1'b0; bus.show_health = 1'b0;
        bus.clear_done = 1'b0; bus.draw_done = 1'b0;
        #12;
        chk("rst.ctrl", 32'(bus.control_signal), 0);
        chk("rst.clear_start", 32'(bus.clear_start), 0);
        chk("rst.draw_start", 32'(bus.draw_start), 0);
        chk("rst.busy", 32'(bus.frame_busy), 0);
        chk("rst.done", 32'(bus.frame_done), 0);
        chk("rst.overrun", 32'(bus.frame_overrun), 0);
        chk("rst.timeout", 32'(bus.timeout_err), 0);
        @(negedge clk); reset = 1'b0;

        // Latency: tick -> clear_start +1; clear_done at T -> select stable T+2, draw_start T+4
        set_masks(4'b0000, 1'b0, 1'b0);
        @(negedge clk); bus.frame_tick = 1'b1;
        @(negedge clk); bus.frame_tick = 1'b0;
        chk("lat.clear_start", 32'(bus.clear_start), 1);
        chk("lat.busy", 32'(bus.frame_busy), 1);
        @(negedge clk);
        chk("lat.clear_pulse", 32'(bus.clear_start), 0);
        bus.clear_done = 1'b1;
        @(negedge clk); bus.clear_done = 1'b0;
        chk("lat.ctrl_t1", 32'(bus.control_signal), 0);
        @(negedge clk);
        chk("lat.ctrl_t2", 32'(bus.control_signal), 1);
        chk("lat.ds_t2", 32'(bus.draw_start), 0);
        @(negedge clk);
        chk("lat.ctrl_t3", 32'(bus.control_signal), 1);
        chk("lat.ds_t3", 32'(bus.draw_start), 0);
        @(negedge clk);
        chk("lat.ds_t4", 32'(bus.draw_start), 1);
        chk("lat.ctrl_t4", 32'(bus.control_signal), 1);
        @(negedge clk);
        chk("lat.ds_t5", 32'(bus.draw_start), 0);
        bus.draw_done = 1'b1;
        @(negedge clk); bus.draw_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.frame_done) seen = 1;
        end
        chk("lat.frame_done", 32'(seen), 1);
        @(negedge clk);
        chk("lat.idle_busy", 32'(bus.frame_busy), 0);
        chk("lat.idle_ctrl", 32'(bus.control_signal), 0);

        // Everything enabled, drawer answers 3 cycles after each request
        set_masks(4'b1111, 1'b1, 1'b1);
        run_frame(3, 0, 0);
        compare_frame("full");
        chk("full.idle_busy", 32'(bus.frame_busy), 0);
        chk("full.idle_ctrl", 32'(bus.control_signal), 0);

        // Sparse mask: 1,2,4,7,8,11,12
        set_masks(4'b0101, 1'b0, 1'b1);
        run_frame(2, 0, 0);
        compare_frame("sparse");

        // Tick with enable low is ignored without any flag
        bus.enable = 1'b0;
        @(negedge clk); bus.frame_tick = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); bus.frame_tick = 1'b0;
            if (bus.clear_start || bus.frame_busy) cnt++;
        end
        chk("disabled.activity", cnt, 0);
        chk("disabled.overrun", 32'(bus.frame_overrun), 0);
        bus.enable = 1'b1;

        // Randomized masks and drawer latency
        for (int r = 0; r < 8; r++) begin
            set_masks(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_frame(int'($urandom_range(1, 5)), 0, 0);
            compare_frame($sformatf("rand%0d", r));
        end
        chk("rand.overrun", 32'(bus.frame_overrun), 0);

        // Second tick during slot 6: sticky overrun, no restart
        set_masks(4'b1111, 1'b1, 1'b1);
        run_frame(2, 6, 0);
        compare_frame("ovr");
        chk("ovr.flag", 32'(bus.frame_overrun), 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.clear_start) cnt++;
        end
        chk("ovr.no_restart", cnt, 0);
        set_masks(4'b0011, 1'b1, 1'b0);
        run_frame(1, 0, 0);
        compare_frame("ovr_next");
        chk("ovr.sticky", 32'(bus.frame_overrun), 1);

        // Async reset while waiting on the slot-4 draw
        set_masks(4'b1111, 1'b1, 1'b1);
        run_frame(2, 0, 4);
        @(negedge clk);
        chk("rstmid.ctrl_before", 32'(bus.control_signal), 4);
        #2 reset = 1'b1;
        #1;
        chk("rstmid.ctrl", 32'(bus.control_signal), 0);
        chk("rstmid.busy", 32'(bus.frame_busy), 0);
        chk("rstmid.overrun", 32'(bus.frame_overrun), 0);
        @(negedge clk);
        chk("rstmid.ctrl_next", 32'(bus.control_signal), 0);
        chk("rstmid.pulses", 32'({bus.clear_start, bus.draw_start, bus.frame_done}), 0);
        reset = 1'b0;
        run_frame(2, 0, 0);
        compare_frame("restart");

        // Drawer never answers slot 2
        set_masks(4'b1111, 1'b1, 1'b1);
        run_frame(2, 0, 2);
`ifdef DRAW_TIMEOUT_EN
        repeat (10) @(negedge clk);
        chk("to.flag_early", 32'(bus.timeout_err), 0);
        chk("to.ctrl_hold", 32'(bus.control_signal), 2);
        @(negedge clk);
        chk("to.flag", 32'(bus.timeout_err), 1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.draw_start) begin
                seen = 1;
                chk("to.next_slot", 32'(bus.control_signal), 3);
            end
        end
        chk("to.resumed", 32'(seen), 1);
        repeat (5) @(negedge clk);
        chk("to.sticky", 32'(bus.timeout_err), 1);
`else
        repeat (60) @(negedge clk);
        chk("hang.ctrl", 32'(bus.control_signal), 2);
        chk("hang.busy", 32'(bus.frame_busy), 1);
        chk("hang.timeout", 32'(bus.timeout_err), 0);
`endif
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("final.timeout", 32'(bus.timeout_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
Per-frame scheduler for the shared draw-object mux and rectangle drawer. On each frame tick it requests a full-screen clear, then steps the mux select (control_signal) through slots 1..14: player, enemies 1-4, bullet, then max/current health bars for enemies 1-4. It skips inactive objects and handshakes each rectangle with the drawer. It sits between the game-logic frame timer and the display mux / VGA plotting FSM.

Parameters:
NUM_SLOTS, 14, last slot index issued (slots 1..NUM_SLOTS)
SETTLE_CYCLES, 2, cycles control_signal is held stable before draw_start (min 1)
TIMEOUT_CYCLES, 40000, draw_done watchdog limit (used only with DRAW_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse, start of frame
enable  in  1  level; frames start only while high
enemy_alive  in  4  bit i = enemy i+1 alive
bullet_active  in  1  bullet in flight
show_health  in  1  draw health-bar slots 7..14
clear_done  in  1  one-cycle pulse from screen-clear engine
draw_done  in  1  one-cycle pulse from rectangle drawer
control_signal  out  4  mux select; 0 when idle
clear_start  out  1  one-cycle request to clear engine
draw_start  out  1  one-cycle request to rectangle drawer
frame_busy  out  1  high from frame accept to FINISH inclusive
frame_done  out  1  one-cycle pulse at end of frame
frame_overrun  out  1  sticky; tick arrived while busy
timeout_err  out  1  sticky watchdog flag (0 without DRAW_TIMEOUT_EN)

Behaviour:
- Reset: all outputs 0; state IDLE; slot pointer 1; settle/watchdog counters 0. Async assert forces this mid-frame; no pending handshake is completed.
- States: IDLE, CLEAR_REQ, CLEAR_WAIT, SELECT, SETTLE, DRAW_REQ, DRAW_WAIT, FINISH.
- IDLE: frame_tick & enable -> CLEAR_REQ, slot <= 1, frame_busy <= 1. Tick with enable=0 is ignored, no flag.
- CLEAR_REQ: clear_start=1 for exactly one cycle -> CLEAR_WAIT.
- CLEAR_WAIT: hold until clear_done -> SELECT.
- SELECT (1 cycle per slot examined): if slot > NUM_SLOTS -> FINISH. Else evaluate slot_en(slot):
  - slot 1: always enabled.
  - slots 2..5: enemy_alive[slot-2].
  - slot 6: bullet_active.
  - slots 7..14: show_health & enemy_alive[(slot-7)>>1].
  - Enabled -> control_signal <= slot, SETTLE. Disabled -> slot+1, stay in SELECT.
  - Mask inputs are sampled live in SELECT; a change affects only slots not yet reached.
- SETTLE: control_signal held; count SETTLE_CYCLES cycles -> DRAW_REQ.
- DRAW_REQ: draw_start=1 for one cycle -> DRAW_WAIT.
- DRAW_WAIT: control_signal held. On draw_done: slot+1 -> SELECT. draw_done outside DRAW_WAIT is ignored.
- FINISH: frame_done=1 for one cycle; control_signal <= 0; frame_busy <= 0 on exit -> IDLE.
- frame_tick while frame_busy: tick dropped, frame_overrun <= 1 (sticky until reset). Tick in the FINISH cycle also counts as overrun.
- enable falling mid-frame: the current frame completes normally.
- Slot pointer is 5 bits, so there is no wrap at NUM_SLOTS+1.
- Latency with no skips: tick -> clear_start at +1. clear_done -> first draw_start at +1 (SELECT) + SETTLE_CYCLES + 1.

Optional Feature:
DRAW_TIMEOUT_EN:
- Defined: watchdog counts cycles in CLEAR_WAIT and DRAW_WAIT. When the count reaches TIMEOUT_CYCLES without the matching done, timeout_err <= 1 (sticky) and the block abandons that item. CLEAR_WAIT -> SELECT; DRAW_WAIT -> slot+1, SELECT. The watchdog clears on entering each wait state.
- Undefined: no counter is instantiated, timeout_err is tied 0, and waits are unbounded.

Test Plan:
1. Reset mid-DRAW_WAIT (slot 4) -> next cycle control_signal=0, frame_busy=0, all pulses 0; a later tick restarts the frame from clear_start.
2. enemy_alive=4'b1111, bullet_active=1, show_health=1, drawer answers draw_done 3 cycles after each draw_start -> 14 draw_starts with control_signal 1..14 in order, then one frame_done.
3. enemy_alive=4'b0101, bullet_active=0, show_health=1 -> draw sequence 1,2,4,7,8,11,12; slots 3,5,6,9,10,13,14 never asserted.
4. SETTLE_CYCLES=2, clear_done at cycle T -> draw_start at T+4 with control_signal=1 stable from T+2.
5. Second frame_tick during slot 6 -> frame_overrun=1 and stays 1; exactly one frame_done for that frame; no second clear_start until the next tick arrives in IDLE.
6. DRAW_TIMEOUT_EN, TIMEOUT_CYCLES=10, drawer never answers slot 2 -> timeout_err=1 after 10 cycles in DRAW_WAIT, sequencer proceeds to slot 3. Without the macro the sequencer stays in slot 2 indefinitely and timeout_err=0.
